// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
// Time-shares one external combinational hex-to-7-segment decoder across up
// to eight HEX digits. Each digit keeps a nibble and a blank flag, written by
// the host over a valid/ready handshake. A three-state scan (LOAD, SAMPLE,
// WAIT) presents each stored nibble to the decoder, then latches the
// decoder's active-low result into a registered per-digit output bus.
//
// Optional feature macro: HEX_SCAN_CTRL_DP_EN
//   Adds a per-digit decimal-point register, written through wr_dp.
//   hex_out then carries 8 bits per digit, with the active-low dp at bit 8i+7.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   wr_valid    host write request
//   wr_ready    write accepted on a cycle where wr_valid && wr_ready
//   wr_idx      target digit (indices >= NUM_DIGITS are dropped and set err)
//   wr_data     hex nibble
//   wr_blank    1 = digit blanked (all segments off)
//   wr_dp       (DP build only) 1 = decimal point lit
//   dec_nibble  registered nibble driven to the shared decoder
//   dec_seg     decoder result, active-low, bit6 = seg a ... bit0 = seg g
//   hex_out     registered active-low segments, digit i in its own slice
//   frame_done  one-cycle pulse after the last digit of a frame is sampled
//   err         sticky flag: an out-of-range write was accepted
//   state_dbg   current scan state, for observation only
//
// Handshake: a write transfers on any rising edge where wr_valid && wr_ready.
// The host holds wr_valid and its payload stable until the write transfers.
// wr_ready is combinational. It drops only while rst is high, or while the
// scan is in LOAD for the same digit the host is targeting (the snapshot read).
module hex_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int REFRESH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [2:0]                wr_idx,
    input  logic [3:0]                wr_data,
    input  logic                      wr_blank,
`ifdef HEX_SCAN_CTRL_DP_EN
    input  logic                      wr_dp,
    output logic [8*NUM_DIGITS-1:0]   hex_out,
`else
    output logic [7*NUM_DIGITS-1:0]   hex_out,
`endif
    output logic [3:0]                dec_nibble,
    input  logic [6:0]                dec_seg,
    output logic                      frame_done,
    output logic                      err,
    output logic [1:0]                state_dbg
);

`ifdef HEX_SCAN_CTRL_DP_EN
    localparam int DW = 8;
`else
    localparam int DW = 7;
`endif

    localparam logic [3:0] ND4      = 4'(NUM_DIGITS);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam int         CW       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [CW-1:0] WAIT_LAST = (REFRESH > 0) ? CW'(REFRESH - 1) : '0;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SAMPLE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      scan_idx;
    logic [CW-1:0]   wait_cnt;
    logic            blank_q;
    logic [3:0]      val [8];
    logic [7:0]      blank;
    logic [DW-1:0]   hex_q [NUM_DIGITS];
    logic            wr_fire;
    logic            wr_in_range;
    logic            last_digit;
`ifdef HEX_SCAN_CTRL_DP_EN
    logic [7:0]      dp;
    logic            dp_q;
`endif

    assign state_dbg   = state;
    assign wr_ready    = !rst && !(state == S_LOAD && wr_idx == scan_idx);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_idx} < ND4);
    assign last_digit  = (scan_idx == LAST_IDX);

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:   state_next = S_SAMPLE;
            S_SAMPLE: begin
                if (last_digit)
                    state_next = (REFRESH == 0) ? S_LOAD : S_WAIT;
                else
                    state_next = S_LOAD;
            end
            S_WAIT:   if (wait_cnt == WAIT_LAST) state_next = S_LOAD;
            default:  state_next = S_LOAD;
        endcase
    end

    // State register, scan datapath and per-digit storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            scan_idx   <= '0;
            wait_cnt   <= '0;
            dec_nibble <= 4'h0;
            blank_q    <= 1'b1;
            frame_done <= 1'b0;
            err        <= 1'b0;
            blank      <= '1;
            for (int i = 0; i < 8; i++) val[i] <= 4'h0;
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= '1;
`ifdef HEX_SCAN_CTRL_DP_EN
            dp         <= '0;
            dp_q       <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;

            case (state)
                S_LOAD: begin
                    // Snapshot this digit; later writes only affect the next frame.
                    dec_nibble <= val[scan_idx];
                    blank_q    <= blank[scan_idx];
`ifdef HEX_SCAN_CTRL_DP_EN
                    dp_q       <= dp[scan_idx];
`endif
                end
                S_SAMPLE: begin
`ifdef HEX_SCAN_CTRL_DP_EN
                    hex_q[scan_idx] <= blank_q ? 8'hFF : {~dp_q, dec_seg};
`else
                    hex_q[scan_idx] <= blank_q ? 7'h7F : dec_seg;
`endif
                    wait_cnt <= '0;
                    if (last_digit) begin
                        scan_idx   <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 3'd1;
                    end
                end
                S_WAIT: wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase

            if (wr_fire) begin
                if (wr_in_range) begin
                    val[wr_idx]   <= wr_data;
                    blank[wr_idx] <= wr_blank;
`ifdef HEX_SCAN_CTRL_DP_EN
                    dp[wr_idx]    <= wr_dp;
`endif
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
        assign hex_out[g*DW +: DW] = hex_q[g];
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl at the default size (6 digits, 4 refresh cycles).
// The bench supplies the external hex decoder. It keeps a behavioural model of
// the digit contents: one image per frame, taken from the stored nibbles and
// blank flags. It also checks frame timing, the write handshake and reset.
module tb_hex_scan_ctrl;

    localparam int ND = 6;
    localparam int RF = 4;
    localparam int W  = 7 * ND;
    localparam int PERIOD = 2 * ND + RF;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_idx;
    logic [3:0]    wr_data;
    logic          wr_blank;
    logic [3:0]    dec_nibble;
    logic [6:0]    dec_seg;
    logic [W-1:0]  hex_out;
    logic          frame_done;
    logic          err;
    logic [1:0]    state_dbg;

    hex_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH(RF)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_blank   (wr_blank),
        .dec_nibble (dec_nibble),
        .dec_seg    (dec_seg),
        .hex_out    (hex_out),
        .frame_done (frame_done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- shared decoder (active-low, bit6 = a) ----------------
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'b000_0001;
            4'h1: seg_of = 7'b100_1111;
            4'h2: seg_of = 7'b001_0010;
            4'h3: seg_of = 7'b000_0110;
            4'h4: seg_of = 7'b100_1100;
            4'h5: seg_of = 7'b010_0100;
            4'h6: seg_of = 7'b010_0000;
            4'h7: seg_of = 7'b000_1111;
            4'h8: seg_of = 7'b000_0000;
            4'h9: seg_of = 7'b000_0100;
            4'hA: seg_of = 7'b000_1000;
            4'hB: seg_of = 7'b110_0000;
            4'hC: seg_of = 7'b011_0001;
            4'hD: seg_of = 7'b100_0010;
            4'hE: seg_of = 7'b011_0000;
            default: seg_of = 7'b011_1000;
        endcase
    endfunction

    assign dec_seg = seg_of(dec_nibble);

    // ---------------- reference model ----------------
    logic [3:0] m_val [ND];
    logic       m_blank [ND];
    logic       m_err;

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i]   = 4'h0;
            m_blank[i] = 1'b1;
        end
        m_err = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [3:0] d, input logic b);
        if (idx < ND) begin
            m_val[idx]   = d;
            m_blank[idx] = b;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Expected entry: {err, hex image of a complete frame}.
    function automatic logic [W:0] model_image();
        logic [W:0] e;
        e = '0;
        for (int i = 0; i < ND; i++)
            e[7*i +: 7] = m_blank[i] ? 7'h7F : seg_of(m_val[i]);
        e[W] = m_err;
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every frame_done, pop the expected frame image and check
    // the frame period (shorter for the first frame after reset, no refresh gap).
    int  mon_cyc = 0;
    logic after_rst = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            mon_cyc   = 0;
            after_rst = 1'b1;
        end else if (frame_done) begin
            check("frame_period", 64'(mon_cyc), after_rst ? 64'(2 * ND) : 64'(PERIOD));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_image: frame_done with no expected frame queued at %0t", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("frame_image", 64'(hex_out), 64'(e[W-1:0]));
                check("frame_err", 64'(err), 64'(e[W]));
            end
            mon_cyc   = 1;
            after_rst = 1'b0;
        end else begin
            mon_cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge of the cycle in which frame_done is high.
    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: no frame_done within %0d cycles", 4 * PERIOD);
        end
    endtask

    // Called at a falling edge; uses one cycle when the write is accepted at once.
    task automatic do_write(input int idx, input logic [3:0] d, input logic b);
        int tries = 0;
        wr_valid = 1'b1;
        wr_idx   = 3'(idx);
        wr_data  = d;
        wr_blank = b;
        #1;
        while (!wr_ready && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL write_accept: idx %0d never accepted", idx);
        end else begin
            @(posedge clk);
            model_write(idx, d, b);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset_mid_frame();
        exp_q.delete();
        model_reset();
        exp_q.push_back(model_image());
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_idx   = 3'd1;
        wr_data  = 4'h9;
        wr_blank = 1'b0;
        #1;
        check("ready_in_rst", 64'(wr_ready), 64'(0));
        @(negedge clk);
        check("rst_hex_ones", 64'(hex_out), 64'({W{1'b1}}));
        check("rst_err_clear", 64'(err), 64'(0));
        check("rst_nibble", 64'(dec_nibble), 64'(0));
        rst      = 1'b0;
        wr_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_idx   = 3'd0;
        wr_data  = 4'h0;
        wr_blank = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_hex", 64'(hex_out), 64'({W{1'b1}}));
        check("reset_frame_done", 64'(frame_done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_nibble", 64'(dec_nibble), 64'(0));
        check("reset_ready", 64'(wr_ready), 64'(0));
        exp_q.push_back(model_image());
        rst = 1'b0;

        // Idle frames: everything stays blank.
        repeat (3) begin
            wait_frame();
            exp_q.push_back(model_image());
        end

        // Directed writes in the refresh gap.
        wait_frame();
        do_write(2, 4'h8, 1'b0);
        exp_q.push_back(model_image());
        wait_frame();
        do_write(0, 4'h0, 1'b0);
        do_write(5, 4'hF, 1'b0);
        exp_q.push_back(model_image());

        // Collision: write digit 3 held from its LOAD cycle (10 cycles after
        // the first refresh cycle). The frame in progress keeps the old value.
        wait_frame();
        exp_q.push_back(model_image());
        repeat (10) @(negedge clk);
        wr_valid = 1'b1;
        wr_idx   = 3'd3;
        wr_data  = 4'hA;
        wr_blank = 1'b0;
        #1;
        check("collide_block", 64'(wr_ready), 64'(0));
        @(negedge clk);
        #1;
        check("collide_accept", 64'(wr_ready), 64'(1));
        @(posedge clk);
        model_write(3, 4'hA, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0;

        // Out-of-range write sets err, display unchanged.
        wait_frame();
        do_write(6, 4'h1, 1'b0);
        exp_q.push_back(model_image());

        // Random writes in the refresh gap.
        repeat (20) begin
            int n;
            wait_frame();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                do_write($urandom_range(0, 7), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0));
            exp_q.push_back(model_image());
        end

        // Reset in the middle of a scan.
        wait_frame();
        exp_q.push_back(model_image());
        repeat (7) @(negedge clk);
        do_reset_mid_frame();

        repeat (5) begin
            int n;
            wait_frame();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                do_write($urandom_range(0, 5), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0));
            exp_q.push_back(model_image());
        end

        wait_frame();
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
